// File: rtl/fir3_stream_sched.sv
// fir3_stream_sched: packs a sample stream into FIR lane triples, gates
// issue on FIFO credit, re-serializes outputs. Option: SCHED_STATS_EN.
module fir3_stream_sched #(
  parameter int NBIT       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBIT-1:0] din,
  input  logic            vin,
  output logic            din_rdy,
  input  logic            flush,
  output logic [NBIT-1:0] fir_din3k,
  output logic [NBIT-1:0] fir_din3k1,
  output logic [NBIT-1:0] fir_din3k2,
  output logic            fir_vin,
  input  logic [NBIT-1:0] fir_dout3k,
  input  logic [NBIT-1:0] fir_dout3k1,
  input  logic [NBIT-1:0] fir_dout3k2,
  input  logic            fir_vout,
  output logic [NBIT-1:0] dout,
  output logic            vout,
  input  logic            dout_rdy,
  output logic            ovf_err
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]     issue_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_S = (AW+2)'(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_P = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [NBIT-1:0] l0;
    logic [NBIT-1:0] l1;
    logic [NBIT-1:0] l2;
  } trip_t;

  logic [1:0]      lane;
  logic [NBIT-1:0] hold0;
  logic [NBIT-1:0] hold1;
  logic            pad_pending;
  logic [AW:0]     inflight;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [AW:0]     occ;
  logic [1:0]      out_lane;
  trip_t           mem [FIFO_DEPTH];
  trip_t           head;
  logic            credit;
  logic            accept;
  logic            pad_issue;
  logic            issue;
  logic            full;
  logic            push;
  logic            pop;
  logic            dec;

  assign occ       = wptr - rptr;
  assign full      = (occ == DEPTH_P);
  assign credit    = ({1'b0, occ} + {1'b0, inflight}) < DEPTH_S;
  assign din_rdy   = rst_n && !pad_pending
                     && !(lane == 2'd2 && !credit);
  assign accept    = vin && din_rdy;
  assign pad_issue = pad_pending && credit;
  assign issue     = (accept && lane == 2'd2) || pad_issue;
  assign vout      = (occ != '0);
  assign pop       = vout && dout_rdy && (out_lane == 2'd2);
  assign push      = fir_vout && (!full || pop);
  assign dec       = fir_vout && (inflight != '0);
  assign head      = mem[rptr[AW-1:0]];

  // Lane packing, zero padding on flush and FIR issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane        <= 2'd0;
      hold0       <= '0;
      hold1       <= '0;
      pad_pending <= 1'b0;
      fir_vin     <= 1'b0;
      fir_din3k   <= '0;
      fir_din3k1  <= '0;
      fir_din3k2  <= '0;
    end else begin
      fir_vin <= issue;
      if (accept) begin
        unique case (lane)
          2'd0: begin
            hold0 <= din;
            lane  <= 2'd1;
          end
          2'd1: begin
            hold1 <= din;
            lane  <= 2'd2;
          end
          default: begin
            fir_din3k  <= hold0;
            fir_din3k1 <= hold1;
            fir_din3k2 <= din;
            lane       <= 2'd0;
          end
        endcase
      end
      if (pad_issue) begin
        fir_din3k   <= hold0;
        fir_din3k1  <= (lane == 2'd2) ? hold1 : '0;
        fir_din3k2  <= '0;
        lane        <= 2'd0;
        pad_pending <= 1'b0;
      end else if (flush && lane != 2'd0
                   && !(accept && lane == 2'd2)) begin
        pad_pending <= 1'b1;
      end
    end
  end

  // Triples issued but not yet returned by the FIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({issue, dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO storage; contents need no reset, pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {fir_dout3k, fir_dout3k1, fir_dout3k2};
    end
  end

  // FIFO pointers, sticky overflow and serializer lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ovf_err  <= 1'b0;
      out_lane <= 2'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (fir_vout && !push) ovf_err <= 1'b1;
      if (vout && dout_rdy) begin
        out_lane <= (out_lane == 2'd2) ? 2'd0 : out_lane + 2'd1;
      end
    end
  end

  // Head lane select; zero while empty.
  always_comb begin
    dout = '0;
    if (vout) begin
      unique case (out_lane)
        2'd0:    dout = head.l0;
        2'd1:    dout = head.l1;
        default: dout = head.l2;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  // Wrapping issue and input-stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 16'd1;
      if (vin && !din_rdy) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir3_stream_sched.sv
// tb_fir3_stream_sched: directed vectors against an identity FIR model
// of latency 3, plus forced FIR outputs for overflow cases.
module tb_fir3_stream_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vin;
  logic        din_rdy;
  logic        flush;
  logic [7:0]  fir_din3k;
  logic [7:0]  fir_din3k1;
  logic [7:0]  fir_din3k2;
  logic        fir_vin;
  logic [7:0]  fir_dout3k;
  logic [7:0]  fir_dout3k1;
  logic [7:0]  fir_dout3k2;
  logic        fir_vout;
  logic [7:0]  dout;
  logic        vout;
  logic        dout_rdy;
  logic        ovf_err;
`ifdef SCHED_STATS_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  logic        fv_force;
  logic [23:0] fv_data;
  logic [2:0]  mv;
  logic [23:0] md0;
  logic [23:0] md1;
  logic [23:0] md2;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          iss_n = 0;
  int          tb_stall = 0;
  logic [7:0]  outq[$];
  int          cycq[$];
  logic [7:0]  expq[$];

  fir3_stream_sched #(.NBIT(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .vin         (vin),
    .din_rdy     (din_rdy),
    .flush       (flush),
    .fir_din3k   (fir_din3k),
    .fir_din3k1  (fir_din3k1),
    .fir_din3k2  (fir_din3k2),
    .fir_vin     (fir_vin),
    .fir_dout3k  (fir_dout3k),
    .fir_dout3k1 (fir_dout3k1),
    .fir_dout3k2 (fir_dout3k2),
    .fir_vout    (fir_vout),
    .dout        (dout),
    .vout        (vout),
    .dout_rdy    (dout_rdy),
    .ovf_err     (ovf_err)
`ifdef SCHED_STATS_EN
    ,
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Identity FIR, latency 3, reset by the same rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv  <= '0;
      md0 <= '0;
      md1 <= '0;
      md2 <= '0;
    end else begin
      mv  <= {mv[1:0], fir_vin};
      md0 <= {fir_din3k, fir_din3k1, fir_din3k2};
      md1 <= md0;
      md2 <= md1;
    end
  end

  assign fir_vout = mv[2] | fv_force;
  assign {fir_dout3k, fir_dout3k1, fir_dout3k2} =
    fv_force ? fv_data : md2;

  // Observe handshakes mid-cycle, after inputs settle.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      outq.delete();
      cycq.delete();
      iss_n    = 0;
      tb_stall = 0;
    end else begin
      if (vout && dout_rdy) begin
        outq.push_back(dout);
        cycq.push_back(cyc);
      end
      if (fir_vin) iss_n++;
      if (vin && !din_rdy) tb_stall++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, "_len"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s_%0d", tag, i), outq[i], expq[i]);
  endtask

  task automatic check_trip(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
    check({tag, "_vin"}, fir_vin, 1);
    check({tag, "_3k"}, fir_din3k, a);
    check({tag, "_3k1"}, fir_din3k1, b);
    check({tag, "_3k2"}, fir_din3k2, c);
  endtask

  task automatic send(input logic [7:0] x, input string tag);
    bit ok;
    ok  = 0;
    din = x;
    vin = 1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (din_rdy) ok = 1;
      @(negedge clk);
      if (ok) break;
    end
    vin = 0;
    check(tag, ok, 1);
  endtask

  task automatic do_reset();
    rst_n    = 0;
    vin      = 0;
    flush    = 0;
    fv_force = 0;
    dout_rdy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    expq.delete();
  endtask

  initial begin
    bit ok;
    rst_n = 0; vin = 0; din = 0; flush = 0;
    dout_rdy = 0; fv_force = 0; fv_data = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_din_rdy", din_rdy, 0);
    check("rst_vout", vout, 0);
    check("rst_dout", dout, 0);
    check("rst_fir_vin", fir_vin, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_fir_din", fir_din3k, 0);
    @(negedge clk);
    rst_n = 1;
    #1 check("post_rst_din_rdy", din_rdy, 1);
    @(negedge clk);

    // Stream 1..6, downstream always ready.
    dout_rdy = 1;
    send(8'd1, "s1_send");
    send(8'd2, "s1_send");
    send(8'd3, "s1_send");
    check_trip("s1_t0", 8'd1, 8'd2, 8'd3);
    send(8'd4, "s1_send");
    check("s1_vin_pulse", fir_vin, 0);
    send(8'd5, "s1_send");
    send(8'd6, "s1_send");
    check_trip("s1_t1", 8'd4, 8'd5, 8'd6);
    repeat (14) @(negedge clk);
    for (int k = 1; k <= 6; k++) expq.push_back(8'(k));
    check_q("s1_out");
    if (cycq.size() >= 6) check("s1_nogap", cycq[5] - cycq[0], 5);

    // Downstream stalled: credits cap issue at four triples.
    do_reset();
    for (int k = 1; k <= 14; k++) send(8'(k), "s2_send");
    din = 8'd15;
    vin = 1;
    repeat (8) @(negedge clk);
`ifdef SCHED_STATS_EN
    check("s2_issue_cnt", issue_cnt, 4);
    check("s2_stall_cnt", stall_cnt, tb_stall);
`endif
    #1;
    check("s2_stall_rdy", din_rdy, 0);
    check("s2_issued", iss_n, 4);
    @(negedge clk);
    dout_rdy = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (din_rdy) ok = 1;
      @(negedge clk);
      if (ok) break;
    end
    vin = 0;
    check("s2_resume", ok, 1);
    repeat (40) @(negedge clk);
    for (int k = 1; k <= 15; k++) expq.push_back(8'(k));
    check_q("s2_out");
    check("s2_ovf", ovf_err, 0);

    // Flush pads partial triples; vin blocked while pending.
    do_reset();
    dout_rdy = 1;
    send(8'd7, "s3_send");
    send(8'd8, "s3_send");
    flush = 1;
    @(negedge clk);
    flush = 0;
    din = 8'd99;
    vin = 1;
    #1 check("s3_pad_block", din_rdy, 0);
    @(negedge clk);
    vin = 0;
    check_trip("s3_pad2", 8'd7, 8'd8, 8'd0);
    send(8'd20, "s3_send");
    send(8'd21, "s3_send");
    send(8'd22, "s3_send");
    check_trip("s3_t", 8'd20, 8'd21, 8'd22);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    check("s3_flush0_vin", fir_vin, 0);
    check("s3_flush0_rdy", din_rdy, 1);
    @(negedge clk);
    send(8'd30, "s3_send");
    flush = 1;
    @(negedge clk);
    flush = 0;
    @(negedge clk);
    check_trip("s3_pad1", 8'd30, 8'd0, 8'd0);
    repeat (16) @(negedge clk);
    expq.push_back(8'd7);  expq.push_back(8'd8);  expq.push_back(8'd0);
    expq.push_back(8'd20); expq.push_back(8'd21); expq.push_back(8'd22);
    expq.push_back(8'd30); expq.push_back(8'd0);  expq.push_back(8'd0);
    check_q("s3_out");

    // Overflow: push into a full FIFO is dropped, error sticks.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      fv_force = 1;
      fv_data  = {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)};
      @(negedge clk);
    end
    fv_force = 0;
    #1;
    check("s4_ovf", ovf_err, 1);
    check("s4_vout", vout, 1);
    check("s4_head", dout, 8'h11);
    repeat (3) @(negedge clk);
    check("s4_sticky", ovf_err, 1);
    dout_rdy = 1;
    repeat (16) @(negedge clk);
    for (int i = 1; i <= 4; i++)
      for (int j = 1; j <= 3; j++) expq.push_back(8'(i * 16 + j));
    check_q("s4_out");
    check("s4_sticky2", ovf_err, 1);
    do_reset();
    #1 check("s4_rst_ovf", ovf_err, 0);
    @(negedge clk);

    // Push coinciding with pop while full is kept.
    for (int i = 6; i <= 9; i++) begin
      fv_force = 1;
      fv_data  = {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)};
      @(negedge clk);
    end
    fv_force = 0;
    dout_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    fv_force = 1;
    fv_data  = {8'hA1, 8'hA2, 8'hA3};
    @(negedge clk);
    fv_force = 0;
    repeat (20) @(negedge clk);
    check("s4b_ovf", ovf_err, 0);
    for (int i = 6; i <= 10; i++)
      for (int j = 1; j <= 3; j++) expq.push_back(8'(i * 16 + j));
    check_q("s4b_out");

    // Asynchronous reset mid-triple and mid-serialization.
    do_reset();
    send(8'd1, "s5_send");
    send(8'd2, "s5_send");
    send(8'd3, "s5_send");
    repeat (5) @(negedge clk);
    send(8'd4, "s5_send");
    dout_rdy = 1;
    @(negedge clk);
    dout_rdy = 0;
    #1;
    check("s5_pre_vout", vout, 1);
    check("s5_pre_dout", dout, 8'd2);
    #2 rst_n = 0;
    #1;
    check("s5_rst_vout", vout, 0);
    check("s5_rst_dout", dout, 0);
    check("s5_rst_fir_vin", fir_vin, 0);
    check("s5_rst_din_rdy", din_rdy, 0);
    check("s5_rst_fir_din", fir_din3k, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    expq.delete();
    dout_rdy = 1;
    send(8'd10, "s5_send");
    send(8'd11, "s5_send");
    send(8'd12, "s5_send");
    check_trip("s5_t", 8'd10, 8'd11, 8'd12);
    repeat (12) @(negedge clk);
    expq.push_back(8'd10);
    expq.push_back(8'd11);
    expq.push_back(8'd12);
    check_q("s5_out");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fir3_stream_sched.md
Name: fir3_stream_sched

Overview:
Scheduler placed between a single-sample stream and the 3-parallel unfolded 11-tap FIR.
- Input side: packs consecutive input samples into lane triples (3k, 3k+1, 3k+2) and issues one FIR valid per triple.
- Output side: captures FIR output triples into a small FIFO and re-serializes them onto a ready/valid output stream.
- Flow control: a credit scheme issues a FIR valid only when a FIFO slot is guaranteed, because the FIR itself has no backpressure.

Parameters:
- NBIT, 8, sample width on all data ports.
- FIFO_DEPTH, 4, output FIFO depth in triples; must be a power of two and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  NBIT  serial input sample.
- vin  in  1  input sample valid.
- din_rdy  out  1  scheduler can accept a sample this cycle.
- flush  in  1  single-cycle pulse; zero-pads a partially collected triple.
- fir_din3k / fir_din3k1 / fir_din3k2  out  NBIT each  lane samples to the FIR.
- fir_vin  out  1  one-cycle valid to the FIR.
- fir_dout3k / fir_dout3k1 / fir_dout3k2  in  NBIT each  FIR lane outputs.
- fir_vout  in  1  FIR output valid.
- dout  out  NBIT  serial output sample.
- vout  out  1  output valid.
- dout_rdy  in  1  downstream ready.
- ovf_err  out  1  sticky error: fir_vout arrived while the FIFO was full.

Behaviour:
- Reset values: all outputs, lane counter, in-flight counter, FIFO pointers and ovf_err are 0; din_rdy=0 during reset and 1 in the first cycle after reset.
- Accept: a sample is accepted when vin && din_rdy.
  - lane counter 0 -> stored to the 3k register; 1 -> stored to the 3k1 register.
  - lane counter 2 -> the sample goes to fir_din3k2 and fir_din3k/3k1 are loaded from the holding registers.
  - All three fir_din outputs update on the same edge that asserts fir_vin for one cycle.
  - Latency: third accepted sample to fir_vin high = 1 cycle.
  - Lane counter wraps 2 -> 0.
- fir_din* hold their value between issues.
- Credits:
  - inflight increments on fir_vin and decrements on fir_vout; a simultaneous increment and decrement leaves it unchanged.
  - Issue is allowed only when occ + inflight < FIFO_DEPTH.
  - din_rdy = !(lane==2 && no credit) && !pad_pending.
  - Lanes 0 and 1 always accept while no pad is pending.
- Flush:
  - flush with lane==0 has no effect.
  - flush with lane 1 or 2 sets pad_pending: missing lanes are filled with 0 and fir_vin is issued at the first cycle with credit; then lane=0 and pad_pending clears.
  - vin during pad_pending is not accepted.
  - flush coinciding with an accept of the lane-2 sample is ignored, since that triple is already complete.
- Output FIFO:
  - fir_vout pushes {3k, 3k1, 3k2}.
  - Push while full drops the data and sets ovf_err; ovf_err is cleared only by reset.
- Serializer:
  - vout = FIFO not empty.
  - dout = head lane selected by out_lane (0 -> 3k, 1 -> 3k1, 2 -> 3k2).
  - vout && dout_rdy advances out_lane; the transition 2 -> 0 pops the head.
  - dout and vout hold while dout_rdy=0.
  - Push and pop in the same cycle is legal at any occupancy, including full: the pop frees the slot in that cycle.
- Reset mid-operation: partial triples, in-flight credits and FIFO contents are discarded. The FIR must be reset by the same rst_n.

Optional Feature:
SCHED_STATS_EN
- Defined: adds outputs issue_cnt[15:0] and stall_cnt[15:0], both reset to 0 and wrapping at 0xFFFF.
  - issue_cnt increments per fir_vin.
  - stall_cnt increments each cycle in which vin=1 and din_rdy=0.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Stream 1..6 with dout_rdy=1 and an FIR model of latency 3 -> fir_vin pulses carry (1,2,3) then (4,5,6); dout emits lane outputs in order 3k, 3k1, 3k2 with no gaps after the first push.
- dout_rdy=0 throughout, 15 samples sent -> 4 triples issued, then din_rdy=0 while lane==2; raising dout_rdy resumes flow with no lost or duplicated samples and ovf_err=0.
- Send 7, 8 then pulse flush -> fir_vin carries (7,8,0); a vin arriving during pad_pending is not accepted; lane counter returns to 0.
- Force fir_vout with the FIFO full and dout_rdy=0 -> ovf_err=1 and stays 1 until rst_n is asserted; FIFO contents are unchanged.
- Assert rst_n=0 asynchronously mid-triple and mid-serialization -> all outputs 0 immediately; after release, samples 10, 11, 12 produce a fresh triple (10, 11, 12).
- SCHED_STATS_EN defined, scenario 2 rerun -> issue_cnt=4 at the stall point; stall_cnt equals the number of cycles with vin=1 and din_rdy=0.
